// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS core: registers the EX->MEM bus, aligns and
// extends SRAM load data, and drives the WB bus plus the GPR and HI/LO forwarding buses.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 145,
  parameter int MEM_TO_WB_WD = 136
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [37:0]             mem_to_id_bus,
  output logic [65:0]             hilo_mem_to_id,
  output logic                    mem_adel
);

  localparam logic STOP = 1'b1;

  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_LW  = 3'b101;

  // Picks the addressed byte/halfword (little-endian) and extends it per load type.
  function automatic logic [31:0] load_align(input logic [2:0]  op,
                                             input logic [1:0]  off,
                                             input logic [31:0] rd);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        res;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (op)
      OP_LB:   res = 32'(b);
      OP_LBU:  res = {24'd0, b};
      OP_LH:   res = 32'(h);
      OP_LHU:  res = {16'd0, h};
      OP_LW:   res = rd;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
    return ((op == OP_LH || op == OP_LHU) && off[0]) || (op == OP_LW && off != 2'd0);
  endfunction

  logic                    held;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus_r;
  logic [31:0]             rdata_buf;
  logic                    buf_valid;

  assign held = (stall[3] == STOP) && (stall[4] == STOP);

  // ---- EX/MEM register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_to_mem_bus_r <= '0;
    end else if (stall[3] == STOP && stall[4] != STOP) begin
      ex_to_mem_bus_r <= '0;
    end else if (stall[3] != STOP) begin
      ex_to_mem_bus_r <= ex_to_mem_bus;
    end
  end

  logic [31:0] ex_pc;
  logic        data_ram_en;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  logic [2:0]  mem_op;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_data;
  logic [31:0] lo_data;

  assign ex_pc       = ex_to_mem_bus_r[144:113];
  assign data_ram_en = ex_to_mem_bus_r[112];
  assign sel_rf_res  = ex_to_mem_bus_r[107];
  assign rf_we       = ex_to_mem_bus_r[106];
  assign rf_waddr    = ex_to_mem_bus_r[105:101];
  assign ex_result   = ex_to_mem_bus_r[100:69];
  assign mem_op      = ex_to_mem_bus_r[68:66];
  assign hi_we       = ex_to_mem_bus_r[65];
  assign lo_we       = ex_to_mem_bus_r[64];
  assign hi_data     = ex_to_mem_bus_r[63:32];
  assign lo_data     = ex_to_mem_bus_r[31:0];

  // The SRAM output is only valid in the first MEM cycle; keep a copy while the stage is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
    end else if (!held) begin
      buf_valid <= 1'b0;
    end else if (data_ram_en && !buf_valid) begin
      buf_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (held && data_ram_en && !buf_valid) begin
      rdata_buf <= data_sram_rdata;
    end
  end

  // ---- MEM combinational result ----
  logic [31:0] rd;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;
  logic        rf_we_o;

  assign rd        = buf_valid ? rdata_buf : data_sram_rdata;
  assign load_data = load_align(mem_op, ex_result[1:0], rd);
  assign mem_adel  = misaligned(mem_op, ex_result[1:0]);
  assign rf_wdata  = sel_rf_res ? load_data : ex_result;
  assign rf_we_o   = rf_we && !mem_adel;

  assign mem_to_wb_bus  = {ex_pc, rf_we_o, rf_waddr, rf_wdata, hi_we, lo_we, hi_data, lo_data};
  assign mem_to_id_bus  = {rf_we_o, rf_waddr, rf_wdata};
  assign hilo_mem_to_id = {hi_we, lo_we, hi_data, lo_data};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, ALU pass-through, loads, misalignment,
// stall hold with read-data buffering, bubble and HI/LO forwarding.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic [144:0] ex_to_mem_bus;
  logic [31:0]  data_sram_rdata;
  logic [135:0] mem_to_wb_bus;
  logic [37:0]  mem_to_id_bus;
  logic [65:0]  hilo_mem_to_id;
  logic         mem_adel;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [5:0] RUN  = 6'b000000;
  localparam logic [5:0] HOLD = 6'b011000;
  localparam logic [5:0] BUBL = 6'b001000;

  mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .ex_to_mem_bus  (ex_to_mem_bus),
    .data_sram_rdata(data_sram_rdata),
    .mem_to_wb_bus  (mem_to_wb_bus),
    .mem_to_id_bus  (mem_to_id_bus),
    .hilo_mem_to_id (hilo_mem_to_id),
    .mem_adel       (mem_adel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [144:0] mk(input logic [31:0] pc, input logic en, input logic sel,
                                      input logic we, input logic [4:0] waddr,
                                      input logic [31:0] res, input logic [2:0] op,
                                      input logic hwe, input logic lwe,
                                      input logic [31:0] hi, input logic [31:0] lo);
    return {pc, en, 4'b0000, sel, we, waddr, res, op, hwe, lwe, hi, lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] exp);
    ex_to_mem_bus = mk(32'h0000_0500, 1'b1, 1'b1, 1'b1, 5'd8, addr, op, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    data_sram_rdata = 32'h80FF7F01;
    #1;
    chk(tag, 136'(mem_to_id_bus), 136'({1'b1, 5'd8, exp}));
  endtask

  task automatic do_misaligned(input string tag, input logic [2:0] op, input logic [31:0] addr);
    ex_to_mem_bus = mk(32'h0000_0600, 1'b1, 1'b1, 1'b1, 5'd9, addr, op, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    data_sram_rdata = 32'h1234_5678;
    #1;
    chk({tag, "_adel"}, 136'(mem_adel), 136'(1'b1));
    chk({tag, "_id_we"}, 136'(mem_to_id_bus[37]), 136'(1'b0));
    chk({tag, "_wb_we"}, 136'(mem_to_wb_bus[103]), 136'(1'b0));
  endtask

  initial begin
    rst             = 1'b1;
    stall           = RUN;
    data_sram_rdata = 32'hDEAD_BEEF;
    ex_to_mem_bus   = mk(32'hBFC0_0000, 1'b1, 1'b1, 1'b1, 5'd31, 32'h0000_1003, 3'b101,
                         1'b1, 1'b1, 32'h5, 32'h6);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb",   mem_to_wb_bus, 136'd0);
    chk("rst_id",   136'(mem_to_id_bus), 136'd0);
    chk("rst_hilo", 136'(hilo_mem_to_id), 136'd0);
    chk("rst_adel", 136'(mem_adel), 136'd0);
    rst = 1'b0;

    ex_to_mem_bus = mk(32'h0000_0400, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 3'b000,
                       1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    chk("alu_id", 136'(mem_to_id_bus), 136'({1'b1, 5'd5, 32'h1234_5678}));
    chk("alu_pc", 136'(mem_to_wb_bus[135:104]), 136'(32'h0000_0400));

    do_load("lb3",  3'b001, 32'h0000_1003, 32'hFFFF_FF80);
    do_load("lbu1", 3'b010, 32'h0000_1001, 32'h0000_007F);
    do_load("lh2",  3'b011, 32'h0000_1002, 32'hFFFF_80FF);
    do_load("lhu0", 3'b100, 32'h0000_1000, 32'h0000_7F01);
    do_load("lw0",  3'b101, 32'h0000_1000, 32'h80FF_7F01);

    do_misaligned("lw_mis", 3'b101, 32'h0000_1002);
    do_misaligned("lh_mis", 3'b011, 32'h0000_1001);

    // lw enters MEM, then the stage is frozen while the SRAM output moves on.
    ex_to_mem_bus = mk(32'h0000_0700, 1'b1, 1'b1, 1'b1, 5'd10, 32'h0000_2000, 3'b101,
                       1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    data_sram_rdata = 32'hAAAA_5555;
    stall           = HOLD;
    #1;
    chk("hold_first", 136'(mem_to_id_bus[31:0]), 136'(32'hAAAA_5555));
    ex_to_mem_bus = mk(32'h0000_0800, 1'b0, 1'b0, 1'b1, 5'd11, 32'h0BAD_0BAD, 3'b000,
                       1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      data_sram_rdata = 32'h0000_0000;
      #1;
      chk($sformatf("hold_c%0d", i), 136'(mem_to_id_bus[31:0]), 136'(32'hAAAA_5555));
    end
    chk("hold_waddr", 136'(mem_to_id_bus[36:32]), 136'({1'b1, 5'd10}) & 136'h1F);
    stall = RUN;
    #1;
    chk("hold_release", 136'(mem_to_id_bus[31:0]), 136'(32'hAAAA_5555));

    stall = BUBL;
    tick();
    chk("bub_wb",   mem_to_wb_bus, 136'd0);
    chk("bub_id",   136'(mem_to_id_bus), 136'd0);
    chk("bub_hilo", 136'(hilo_mem_to_id), 136'd0);
    stall = RUN;

    ex_to_mem_bus = mk(32'h0000_0900, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 3'b000,
                       1'b1, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE);
    tick();
    chk("hilo_id", 136'(hilo_mem_to_id), 136'({1'b1, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE}));
    chk("hilo_wb", 136'(mem_to_wb_bus[65:0]), 136'({1'b1, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE}));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
